id_ex_pipeline_reg: RTL and testbench
=====================================

// Module: id_ex_pipeline_reg
// PURPOSE
//  Decode->Execute pipeline register of the 5-stage RISC-V core.
//  Captures the decode-stage control word, which includes the 3-bit ALU control from the ALU decoder.
//  Also captures register operands, immediate, PC and register indices; presents them to the execute stage one cycle later.
//  Supports hazard-unit stall (hold) and flush (bubble insert).
//  Flags illegal ALU control codes and keeps a saturating bubble counter for debug.
// PARAMETERS
//  DATA_WIDTH  32  width of operands, immediate, PC
//  ADDR_WIDTH   5  register index width
//  CNT_WIDTH   16  bubble counter width
// PORTS
//  clk            in   1           clock, rising edge
//  rst            in   1           asynchronous, active-high reset
//  StallE_i       in   1           hold current contents
//  FlushE_i       in   1           load a bubble next edge
//  ValidD_i       in   1           decode slot holds a real instruction
//  RegWriteD_i    in   1           control: register write
//  MemWriteD_i    in   1           control: memory write
//  ResultSrcD_i   in   2           control: writeback mux select
//  BranchD_i      in   1           control: branch
//  JumpD_i        in   1           control: jump
//  ALUSrcD_i      in   1           control: ALU B = immediate
//  ALUControlD_i  in   3           ALU operation code
//  RD1D_i         in   DATA_WIDTH  rs1 value
//  RD2D_i         in   DATA_WIDTH  rs2 value
//  ImmExtD_i      in   DATA_WIDTH  sign-extended immediate
//  PCD_i          in   DATA_WIDTH  instruction PC
//  PCPlus4D_i     in   DATA_WIDTH  PC+4
//  Rs1D_i, Rs2D_i, RdD_i  in  ADDR_WIDTH each  register indices
//  *E_o           out  same        registered copy of every *D_i above (ValidE_o ... RdE_o)
//  IllegalE_o     out  1           registered: ValidD_i && ALUControlD_i==ALU_ILLEGAL
//  BubbleCnt_o    out  CNT_WIDTH   count of edges where ValidE_o was loaded 0
// BEHAVIOUR
//  Reset (async on rst rising, held while rst=1):
//   - all outputs 0 (ALUControlE_o=3'b000, BubbleCnt_o=0).
//   - The reset state is a bubble.
//  Per rising edge, priority rst > FlushE_i > StallE_i > load:
//   - Flush: every E output <= 0, including data and indices; IllegalE_o <= 0.
//     Flush overrides a simultaneous stall.
//   - Stall (no flush): all E outputs hold, including IllegalE_o.
//   - Load: every E output <= its D input after 1 cycle latency.
//     If ValidD_i=0, all control outputs (RegWrite, MemWrite, Branch, Jump) load 0 regardless of inputs; data still loads.
//  Bubble guarantee: ValidE_o=0 implies RegWriteE_o=MemWriteE_o=BranchE_o=JumpE_o=0.
//   - This holds at every cycle, including after reset.
//  IllegalE_o:
//   - ALU_ILLEGAL=3'b111; the ALU control is still passed through unchanged.
//   - Masked to 0 when the slot is a bubble.
//  BubbleCnt_o:
//   - Increments on an edge that is not a stall and loads ValidE_o=0 (flush, or load with ValidD_i=0).
//   - Saturates at 2**CNT_WIDTH-1 with no wrap.
//   - Stall edges do not count.
//  Reset asserted mid-stall or mid-flush: outputs go to the reset state immediately; the first edge after rst falls is a normal load.
//  No combinational path from any input to any output.
// STRUCTURE
//  riscv_pkg (shared):
//   - ALU codes ALU_ADD=000, ALU_SUB=001, ALU_AND=010, ALU_OR=011, ALU_SLT=101, ALU_ILLEGAL=111
//   - ResultSrc encodings
//   - packed struct ctrl_t {RegWrite, MemWrite, ResultSrc, Branch, Jump, ALUSrc, ALUControl}
//   - used by the ALU decoder, this block, and the execute stage
//  Sub-module pipe_reg #(WIDTH): async-reset flop with en/clr.
//   - One instance for ctrl_t, one for the data bundle.
//  Bubble counter and illegal flag are written inline.
// TESTING
//  1. rst=1 with random D inputs -> all outputs 0; release, load ADD, rd=5 -> next cycle ALUControlE_o=000, RdE_o=5, ValidE_o=1.
//  2. Load SUB, RD1=0x10 RD2=0x3; then StallE_i=1 for 3 cycles with new D values -> E holds 001/0x10/0x3; BubbleCnt_o unchanged.
//  3. Stall=1 and Flush=1 on the same edge -> all E outputs 0; BubbleCnt_o +1.
//  4. ValidD_i=0 with RegWriteD_i=1, MemWriteD_i=1 -> RegWriteE_o=MemWriteE_o=0, RD1E_o loaded, BubbleCnt_o +1.
//  5. ALUControlD_i=111 with ValidD_i=1 -> IllegalE_o=1, ALUControlE_o=111.
//     Repeat with ValidD_i=0 -> IllegalE_o=0.
//  6. CNT_WIDTH=2 with 5 flushes -> BubbleCnt_o reaches 3 and holds.
//     Then assert rst mid-stall -> BubbleCnt_o=0 asynchronously.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the 5-stage RISC-V core: ALU operation codes,
// writeback mux encodings and the packed decode control word.
package riscv_pkg;

    localparam logic [2:0] ALU_ADD     = 3'b000;
    localparam logic [2:0] ALU_SUB     = 3'b001;
    localparam logic [2:0] ALU_AND     = 3'b010;
    localparam logic [2:0] ALU_OR      = 3'b011;
    localparam logic [2:0] ALU_SLT     = 3'b101;
    localparam logic [2:0] ALU_ILLEGAL = 3'b111;

    localparam logic [1:0] RESULT_ALU = 2'b00;
    localparam logic [1:0] RESULT_MEM = 2'b01;
    localparam logic [1:0] RESULT_PC4 = 2'b10;

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic [1:0] result_src;
        logic       branch;
        logic       jump;
        logic       alu_src;
        logic [2:0] alu_control;
    } ctrl_t;

    // A bubble must never write state or redirect the PC, so the
    // side-effecting control bits are cleared when the slot is not valid.
    function automatic ctrl_t bubble_mask(input ctrl_t c, input logic valid);
        ctrl_t r;
        r = c;
        if (!valid) begin
            r.reg_write = 1'b0;
            r.mem_write = 1'b0;
            r.branch    = 1'b0;
            r.jump      = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/pipe_reg.sv
// Generic pipeline flop bundle: asynchronous reset, synchronous clear
// (which wins over enable) and load enable.
module pipe_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Clear inserts a zero bubble even when the stage is also being held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= '0;
        else if (clr)
            q <= '0;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/id_ex_pipeline_reg.sv
// Decode -> Execute pipeline register. Registers the control word and the
// operand bundle, handles hazard stall/flush, flags illegal ALU codes and
// keeps a saturating count of bubbles entering execute.
module id_ex_pipeline_reg
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  StallE_i,
    input  logic                  FlushE_i,
    input  logic                  ValidD_i,
    input  logic                  RegWriteD_i,
    input  logic                  MemWriteD_i,
    input  logic [1:0]            ResultSrcD_i,
    input  logic                  BranchD_i,
    input  logic                  JumpD_i,
    input  logic                  ALUSrcD_i,
    input  logic [2:0]            ALUControlD_i,
    input  logic [DATA_WIDTH-1:0] RD1D_i,
    input  logic [DATA_WIDTH-1:0] RD2D_i,
    input  logic [DATA_WIDTH-1:0] ImmExtD_i,
    input  logic [DATA_WIDTH-1:0] PCD_i,
    input  logic [DATA_WIDTH-1:0] PCPlus4D_i,
    input  logic [ADDR_WIDTH-1:0] Rs1D_i,
    input  logic [ADDR_WIDTH-1:0] Rs2D_i,
    input  logic [ADDR_WIDTH-1:0] RdD_i,
    output logic                  ValidE_o,
    output logic                  RegWriteE_o,
    output logic                  MemWriteE_o,
    output logic [1:0]            ResultSrcE_o,
    output logic                  BranchE_o,
    output logic                  JumpE_o,
    output logic                  ALUSrcE_o,
    output logic [2:0]            ALUControlE_o,
    output logic [DATA_WIDTH-1:0] RD1E_o,
    output logic [DATA_WIDTH-1:0] RD2E_o,
    output logic [DATA_WIDTH-1:0] ImmExtE_o,
    output logic [DATA_WIDTH-1:0] PCE_o,
    output logic [DATA_WIDTH-1:0] PCPlus4E_o,
    output logic [ADDR_WIDTH-1:0] Rs1E_o,
    output logic [ADDR_WIDTH-1:0] Rs2E_o,
    output logic [ADDR_WIDTH-1:0] RdE_o,
    output logic                  IllegalE_o,
    output logic [CNT_WIDTH-1:0]  BubbleCnt_o
);

    localparam int DATA_BITS = 5 * DATA_WIDTH + 3 * ADDR_WIDTH;

    ctrl_t                ctrl_d;
    ctrl_t                ctrl_q;
    logic [DATA_BITS-1:0] data_d;
    logic [DATA_BITS-1:0] data_q;
    logic                 load_en;
    logic                 bubble_edge;
    logic                 valid_q;
    logic                 illegal_q;
    logic [CNT_WIDTH-1:0] bubble_cnt;

    assign load_en = ~StallE_i;

    // An edge inserts a bubble when it flushes (even during a stall) or
    // loads a slot that decode marked as not holding an instruction.
    assign bubble_edge = FlushE_i | (~StallE_i & ~ValidD_i);

    // Assemble the decode control word, stripping side effects from bubbles.
    always_comb begin
        ctrl_d = '0;
        ctrl_d.reg_write   = RegWriteD_i;
        ctrl_d.mem_write   = MemWriteD_i;
        ctrl_d.result_src  = ResultSrcD_i;
        ctrl_d.branch      = BranchD_i;
        ctrl_d.jump        = JumpD_i;
        ctrl_d.alu_src     = ALUSrcD_i;
        ctrl_d.alu_control = ALUControlD_i;
        ctrl_d = bubble_mask(ctrl_d, ValidD_i);
    end

    assign data_d = {RD1D_i, RD2D_i, ImmExtD_i, PCD_i, PCPlus4D_i, Rs1D_i, Rs2D_i, RdD_i};

    pipe_reg #(.WIDTH($bits(ctrl_t))) u_ctrl_reg (
        .clk (clk),
        .rst (rst),
        .en  (load_en),
        .clr (FlushE_i),
        .d   (ctrl_d),
        .q   (ctrl_q)
    );

    pipe_reg #(.WIDTH(DATA_BITS)) u_data_reg (
        .clk (clk),
        .rst (rst),
        .en  (load_en),
        .clr (FlushE_i),
        .d   (data_d),
        .q   (data_q)
    );

    // Valid bit and illegal-op flag follow the same flush/stall priority;
    // the flag is only raised for real instructions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else if (FlushE_i) begin
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else if (load_en) begin
            valid_q   <= ValidD_i;
            illegal_q <= ValidD_i && (ALUControlD_i == ALU_ILLEGAL);
        end
    end

    // Debug bubble counter, saturating at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            bubble_cnt <= '0;
        else if (bubble_edge && (bubble_cnt != {CNT_WIDTH{1'b1}}))
            bubble_cnt <= bubble_cnt + 1'b1;
    end

    assign ValidE_o      = valid_q;
    assign IllegalE_o    = illegal_q;
    assign BubbleCnt_o   = bubble_cnt;
    assign RegWriteE_o   = ctrl_q.reg_write;
    assign MemWriteE_o   = ctrl_q.mem_write;
    assign ResultSrcE_o  = ctrl_q.result_src;
    assign BranchE_o     = ctrl_q.branch;
    assign JumpE_o       = ctrl_q.jump;
    assign ALUSrcE_o     = ctrl_q.alu_src;
    assign ALUControlE_o = ctrl_q.alu_control;
    assign {RD1E_o, RD2E_o, ImmExtE_o, PCE_o, PCPlus4E_o, Rs1E_o, Rs2E_o, RdE_o} = data_q;

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// Self-checking bench for id_ex_pipeline_reg: a vector table for
// single-edge load/stall/flush behaviour plus hand-written sequences for
// reset, multi-cycle stall, counter saturation and async reset.
module tb_id_ex_pipeline_reg;

    typedef struct {
        logic        valid;
        logic        rw;
        logic        mw;
        logic [1:0]  rs;
        logic        br;
        logic        jp;
        logic        asrc;
        logic [2:0]  alu;
        logic [31:0] rd1;
        logic [4:0]  rd;
        logic        stall;
        logic        flush;
        logic [11:0] exp_ctrl;
        logic [31:0] exp_rd1;
        logic [4:0]  exp_rd;
        logic [15:0] exp_cnt;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        stall_e, flush_e, valid_d, reg_write_d, mem_write_d;
    logic [1:0]  result_src_d;
    logic        branch_d, jump_d, alu_src_d;
    logic [2:0]  alu_control_d;
    logic [31:0] rd1_d, rd2_d, imm_d, pc_d, pc4_d;
    logic [4:0]  rs1_d, rs2_d, rd_d;

    logic        valid_e, reg_write_e, mem_write_e, branch_e, jump_e, alu_src_e, illegal_e;
    logic [1:0]  result_src_e;
    logic [2:0]  alu_control_e;
    logic [31:0] rd1_e, rd2_e, imm_e, pc_e, pc4_e;
    logic [4:0]  rs1_e, rs2_e, rd_e;
    logic [15:0] bubble_cnt;

    logic        s_valid_e, s_reg_write_e, s_mem_write_e, s_branch_e, s_jump_e, s_alu_src_e, s_illegal_e;
    logic [1:0]  s_result_src_e;
    logic [2:0]  s_alu_control_e;
    logic [31:0] s_rd1_e, s_rd2_e, s_imm_e, s_pc_e, s_pc4_e;
    logic [4:0]  s_rs1_e, s_rs2_e, s_rd_e;
    logic [1:0]  s_bubble_cnt;

    int checks = 0;
    int errors = 0;
    vec_t vecs[10];

    logic [11:0] ctrl_e;
    assign ctrl_e = {valid_e, illegal_e, reg_write_e, mem_write_e, result_src_e,
                     branch_e, jump_e, alu_src_e, alu_control_e};

    id_ex_pipeline_reg dut (
        .clk(clk), .rst(rst), .StallE_i(stall_e), .FlushE_i(flush_e), .ValidD_i(valid_d),
        .RegWriteD_i(reg_write_d), .MemWriteD_i(mem_write_d), .ResultSrcD_i(result_src_d),
        .BranchD_i(branch_d), .JumpD_i(jump_d), .ALUSrcD_i(alu_src_d), .ALUControlD_i(alu_control_d),
        .RD1D_i(rd1_d), .RD2D_i(rd2_d), .ImmExtD_i(imm_d), .PCD_i(pc_d), .PCPlus4D_i(pc4_d),
        .Rs1D_i(rs1_d), .Rs2D_i(rs2_d), .RdD_i(rd_d),
        .ValidE_o(valid_e), .RegWriteE_o(reg_write_e), .MemWriteE_o(mem_write_e),
        .ResultSrcE_o(result_src_e), .BranchE_o(branch_e), .JumpE_o(jump_e), .ALUSrcE_o(alu_src_e),
        .ALUControlE_o(alu_control_e), .RD1E_o(rd1_e), .RD2E_o(rd2_e), .ImmExtE_o(imm_e),
        .PCE_o(pc_e), .PCPlus4E_o(pc4_e), .Rs1E_o(rs1_e), .Rs2E_o(rs2_e), .RdE_o(rd_e),
        .IllegalE_o(illegal_e), .BubbleCnt_o(bubble_cnt)
    );

    id_ex_pipeline_reg #(.CNT_WIDTH(2)) dut_small (
        .clk(clk), .rst(rst), .StallE_i(stall_e), .FlushE_i(flush_e), .ValidD_i(valid_d),
        .RegWriteD_i(reg_write_d), .MemWriteD_i(mem_write_d), .ResultSrcD_i(result_src_d),
        .BranchD_i(branch_d), .JumpD_i(jump_d), .ALUSrcD_i(alu_src_d), .ALUControlD_i(alu_control_d),
        .RD1D_i(rd1_d), .RD2D_i(rd2_d), .ImmExtD_i(imm_d), .PCD_i(pc_d), .PCPlus4D_i(pc4_d),
        .Rs1D_i(rs1_d), .Rs2D_i(rs2_d), .RdD_i(rd_d),
        .ValidE_o(s_valid_e), .RegWriteE_o(s_reg_write_e), .MemWriteE_o(s_mem_write_e),
        .ResultSrcE_o(s_result_src_e), .BranchE_o(s_branch_e), .JumpE_o(s_jump_e), .ALUSrcE_o(s_alu_src_e),
        .ALUControlE_o(s_alu_control_e), .RD1E_o(s_rd1_e), .RD2E_o(s_rd2_e), .ImmExtE_o(s_imm_e),
        .PCE_o(s_pc_e), .PCPlus4E_o(s_pc4_e), .Rs1E_o(s_rs1_e), .Rs2E_o(s_rs2_e), .RdE_o(s_rd_e),
        .IllegalE_o(s_illegal_e), .BubbleCnt_o(s_bubble_cnt)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setIdle();
        stall_e = 1'b0; flush_e = 1'b0; valid_d = 1'b0;
        reg_write_d = 1'b0; mem_write_d = 1'b0; result_src_d = 2'b00;
        branch_d = 1'b0; jump_d = 1'b0; alu_src_d = 1'b0; alu_control_d = 3'b000;
        rd1_d = '0; rd2_d = '0; imm_d = '0; pc_d = '0; pc4_d = '0;
        rs1_d = '0; rs2_d = '0; rd_d = '0;
    endtask

    task automatic applyStimulus(input vec_t v);
        setIdle();
        valid_d = v.valid; reg_write_d = v.rw; mem_write_d = v.mw; result_src_d = v.rs;
        branch_d = v.br; jump_d = v.jp; alu_src_d = v.asrc; alu_control_d = v.alu;
        rd1_d = v.rd1; rd_d = v.rd; stall_e = v.stall; flush_e = v.flush;
        step();
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_ctrl"}, {52'd0, ctrl_e}, 64'd0);
        checkOutput({tag, "_rd1_rd2"}, {rd1_e, rd2_e}, 64'd0);
        checkOutput({tag, "_imm_pc"}, {imm_e, pc_e}, 64'd0);
        checkOutput({tag, "_pc4_idx"}, {17'd0, pc4_e, rs1_e, rs2_e, rd_e}, 64'd0);
        checkOutput({tag, "_cnt"}, {46'd0, s_bubble_cnt, bubble_cnt}, 64'd0);
    endtask

    initial begin
        // sequential table: counter and held values carry across rows
        vecs[0] = '{valid:1'b1, rw:1'b1, mw:1'b0, rs:2'b00, br:1'b0, jp:1'b0, asrc:1'b1, alu:3'b000,
                    rd1:32'h1234, rd:5'd5, stall:1'b0, flush:1'b0,
                    exp_ctrl:12'b1_0_1_0_00_0_0_1_000, exp_rd1:32'h1234, exp_rd:5'd5, exp_cnt:16'd0};
        vecs[1] = '{valid:1'b0, rw:1'b1, mw:1'b1, rs:2'b01, br:1'b1, jp:1'b1, asrc:1'b1, alu:3'b010,
                    rd1:32'hAAAA, rd:5'd7, stall:1'b0, flush:1'b0,
                    exp_ctrl:12'b0_0_0_0_01_0_0_1_010, exp_rd1:32'hAAAA, exp_rd:5'd7, exp_cnt:16'd1};
        vecs[2] = '{valid:1'b1, rw:1'b0, mw:1'b1, rs:2'b10, br:1'b0, jp:1'b0, asrc:1'b0, alu:3'b111,
                    rd1:32'h55, rd:5'd31, stall:1'b0, flush:1'b0,
                    exp_ctrl:12'b1_1_0_1_10_0_0_0_111, exp_rd1:32'h55, exp_rd:5'd31, exp_cnt:16'd1};
        vecs[3] = '{valid:1'b0, rw:1'b1, mw:1'b0, rs:2'b00, br:1'b0, jp:1'b1, asrc:1'b0, alu:3'b111,
                    rd1:32'h66, rd:5'd3, stall:1'b0, flush:1'b0,
                    exp_ctrl:12'b0_0_0_0_00_0_0_0_111, exp_rd1:32'h66, exp_rd:5'd3, exp_cnt:16'd2};
        vecs[4] = '{valid:1'b1, rw:1'b1, mw:1'b0, rs:2'b00, br:1'b0, jp:1'b0, asrc:1'b0, alu:3'b001,
                    rd1:32'h77, rd:5'd9, stall:1'b1, flush:1'b0,
                    exp_ctrl:12'b0_0_0_0_00_0_0_0_111, exp_rd1:32'h66, exp_rd:5'd3, exp_cnt:16'd2};
        vecs[5] = '{valid:1'b1, rw:1'b1, mw:1'b0, rs:2'b00, br:1'b0, jp:1'b0, asrc:1'b0, alu:3'b011,
                    rd1:32'h88, rd:5'd10, stall:1'b1, flush:1'b1,
                    exp_ctrl:12'd0, exp_rd1:32'h0, exp_rd:5'd0, exp_cnt:16'd3};
        vecs[6] = '{valid:1'b1, rw:1'b0, mw:1'b0, rs:2'b11, br:1'b1, jp:1'b1, asrc:1'b0, alu:3'b101,
                    rd1:32'hDEADBEEF, rd:5'd1, stall:1'b0, flush:1'b0,
                    exp_ctrl:12'b1_0_0_0_11_1_1_0_101, exp_rd1:32'hDEADBEEF, exp_rd:5'd1, exp_cnt:16'd3};
        vecs[7] = '{valid:1'b1, rw:1'b1, mw:1'b0, rs:2'b00, br:1'b0, jp:1'b0, asrc:1'b0, alu:3'b000,
                    rd1:32'h99, rd:5'd2, stall:1'b0, flush:1'b1,
                    exp_ctrl:12'd0, exp_rd1:32'h0, exp_rd:5'd0, exp_cnt:16'd4};
        vecs[8] = '{valid:1'b1, rw:1'b1, mw:1'b1, rs:2'b00, br:1'b0, jp:1'b0, asrc:1'b0, alu:3'b000,
                    rd1:32'hAA, rd:5'd4, stall:1'b1, flush:1'b0,
                    exp_ctrl:12'd0, exp_rd1:32'h0, exp_rd:5'd0, exp_cnt:16'd4};
        vecs[9] = '{valid:1'b1, rw:1'b1, mw:1'b0, rs:2'b01, br:1'b0, jp:1'b0, asrc:1'b0, alu:3'b001,
                    rd1:32'hFFFFFFFF, rd:5'd31, stall:1'b0, flush:1'b0,
                    exp_ctrl:12'b1_0_1_0_01_0_0_0_001, exp_rd1:32'hFFFFFFFF, exp_rd:5'd31, exp_cnt:16'd4};

        // reset with random decode inputs: everything reads as a bubble
        setIdle();
        rst = 1'b1;
        valid_d = 1'b1; reg_write_d = 1'b1; mem_write_d = 1'b1; branch_d = 1'b1; jump_d = 1'b1;
        alu_control_d = 3'($urandom); result_src_d = 2'($urandom);
        rd1_d = $urandom; rd2_d = $urandom; imm_d = $urandom; pc_d = $urandom; pc4_d = $urandom;
        rs1_d = 5'($urandom); rs2_d = 5'($urandom); rd_d = 5'($urandom);
        step();
        step();
        checkAllZero("reset");

        // first load after reset: ADD to x5
        rst = 1'b0;
        setIdle();
        valid_d = 1'b1; reg_write_d = 1'b1; alu_control_d = 3'b000; rd_d = 5'd5;
        step();
        checkOutput("load_add_alu", {61'd0, alu_control_e}, 64'd0);
        checkOutput("load_add_rd", {59'd0, rd_e}, 64'd5);
        checkOutput("load_add_valid", {63'd0, valid_e}, 64'd1);

        // SUB loaded, then held for three stall cycles while decode changes
        setIdle();
        valid_d = 1'b1; reg_write_d = 1'b1; alu_control_d = 3'b001;
        rd1_d = 32'h10; rd2_d = 32'h3; imm_d = 32'hFFFFFFF0; pc_d = 32'h100; pc4_d = 32'h104;
        rs1_d = 5'd1; rs2_d = 5'd2; rd_d = 5'd3;
        step();
        checkOutput("sub_imm_pc", {imm_e, pc_e}, {32'hFFFFFFF0, 32'h100});
        checkOutput("sub_pc4_idx", {17'd0, pc4_e, rs1_e, rs2_e, rd_e}, {17'd0, 32'h104, 5'd1, 5'd2, 5'd3});
        for (int i = 0; i < 3; i++) begin
            stall_e = 1'b1;
            valid_d = 1'b0; alu_control_d = 3'(i + 2);
            rd1_d = 32'hC0DE0000 + i; rd2_d = 32'hBEEF0000 + i; imm_d = 32'h0; pc_d = 32'h200;
            step();
            checkOutput($sformatf("stall%0d_alu", i), {61'd0, alu_control_e}, 64'd1);
            checkOutput($sformatf("stall%0d_ops", i), {rd1_e, rd2_e}, {32'h10, 32'h3});
            checkOutput($sformatf("stall%0d_imm_pc", i), {imm_e, pc_e}, {32'hFFFFFFF0, 32'h100});
            checkOutput($sformatf("stall%0d_cnt", i), {48'd0, bubble_cnt}, 64'd0);
        end

        // table of single-edge behaviours
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d_ctrl", i), {52'd0, ctrl_e}, {52'd0, vecs[i].exp_ctrl});
            checkOutput($sformatf("vec%0d_rd1", i), {32'd0, rd1_e}, {32'd0, vecs[i].exp_rd1});
            checkOutput($sformatf("vec%0d_rd", i), {59'd0, rd_e}, {59'd0, vecs[i].exp_rd});
            checkOutput($sformatf("vec%0d_cnt", i), {48'd0, bubble_cnt}, {48'd0, vecs[i].exp_cnt});
        end

        // saturation of the narrow counter
        setIdle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            setIdle();
            valid_d = 1'b1; flush_e = 1'b1;
            step();
            checkOutput($sformatf("sat%0d_small", i), {62'd0, s_bubble_cnt}, (i > 3) ? 64'd3 : 64'(i));
            checkOutput($sformatf("sat%0d_big", i), {48'd0, bubble_cnt}, 64'(i));
        end

        // reset asserted between edges during a stall takes effect at once
        setIdle();
        stall_e = 1'b1;
        step();
        #2;
        rst = 1'b1;
        #1;
        checkAllZero("async_rst");

        // first edge after reset release is an ordinary load
        setIdle();
        step();
        rst = 1'b0;
        valid_d = 1'b1; reg_write_d = 1'b1; alu_control_d = 3'b011; rd_d = 5'd9;
        step();
        checkOutput("post_rst_load", {47'd0, valid_e, reg_write_e, alu_control_e, rd_e, s_bubble_cnt, bubble_cnt},
                    {47'd0, 1'b1, 1'b1, 3'b011, 5'd9, 2'd0, 16'd0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
